conv_sr_feeder: RTL and testbench

//  Upstream controller for the convolution window shift-register chain.
//  - Accepts a raster-scan 8-bit pixel stream over valid/ready.
//  - Drives the chain's enable and column_shift_in, and tracks column/row position.
//  - Flags when p_window_out holds a complete, non-wrapping window.
//  - Stalls the pixel stream when the downstream window consumer applies backpressure.

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_pos_counter.sv | 54 +++++
 rtl/conv_sr_feeder.sv | 139 +++++++++++++
 tb/tb_conv_sr_feeder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window feeder: pixel width and the
// feeder state encoding.
package conv_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter: column wraps at the image width and advances the
// row; flags the last column and the last pixel of the frame.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    input  logic                          i_inc,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
    output logic                          o_last_col,
    output logic                          o_last_pix
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] C_LAST_ROW = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_last_col;
    logic          w_last_row;

    assign w_last_col = (r_col == C_LAST_COL);
    assign w_last_row = (r_row == C_LAST_ROW);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (w_last_col) begin
                r_col <= '0;
                // Explicit row wrap keeps non-power-of-two heights correct.
                r_row <= w_last_row ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last_col = w_last_col;
    assign o_last_pix = w_last_col & w_last_row;

endmodule

// File: rtl/conv_sr_feeder.sv
// Upstream controller for the convolution window shift-register chain: gates the
// raster pixel stream, tracks position and flags complete, non-wrapping windows.
module conv_sr_feeder
    import conv_pkg::*;
#(
    parameter int P_SR_DEPTH  = 3,
    parameter int NUM_SR_ROWS = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [PIX_W-1:0]              i_pixel,
    input  logic                          i_pixel_valid,
    output logic                          o_pixel_ready,
    output logic                          o_sr_enable,
    output logic [PIX_W-1:0]              o_sr_pixel,
    output logic                          o_window_valid,
    input  logic                          i_window_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_win_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_win_row,
    output logic                          o_frame_done,
    output logic                          o_busy
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] C_FIRST_COL = CW'(P_SR_DEPTH - 1);
    localparam logic [RW-1:0] C_FIRST_ROW = RW'(NUM_SR_ROWS - 1);

    feed_state_t   r_state;
    feed_state_t   w_state_next;
    logic          r_window_valid;
    logic [CW-1:0] r_win_col;
    logic [RW-1:0] r_win_row;

    logic          w_feeding;
    logic          w_stalled;
    logic          w_pixel_ready;
    logic          w_accept;
    logic          w_qualify;
    logic          w_frame_done;
    logic          w_clr;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_pix;
    logic          w_unused_last_col;

    // An unconsumed window blocks the stream so the chain cannot overwrite it.
    assign w_feeding     = (r_state == ST_FILL) || (r_state == ST_STREAM);
    assign w_stalled     = r_window_valid & ~i_window_ready;
    assign w_pixel_ready = w_feeding & ~w_stalled;
    assign w_accept      = i_pixel_valid & w_pixel_ready;
    assign w_clr         = (r_state == ST_IDLE) & i_start;

    // The column test alone rejects windows that straddle a row boundary.
    assign w_qualify = w_accept && (w_col >= C_FIRST_COL) && (w_row >= C_FIRST_ROW);

    assign w_unused_last_col = w_last_col;

    conv_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_inc      (w_accept),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last_col (w_last_col),
        .o_last_pix (w_last_pix)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_qualify) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_accept && w_last_pix) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_window_valid && i_window_ready) begin
                    w_state_next = ST_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A qualifying accept wins over the consume so back-to-back windows stay valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window_valid <= 1'b0;
            r_win_col      <= '0;
            r_win_row      <= '0;
        end else if (w_qualify) begin
            r_window_valid <= 1'b1;
            r_win_col      <= w_col;
            r_win_row      <= w_row;
        end else if (i_window_ready) begin
            r_window_valid <= 1'b0;
        end
    end

    assign o_pixel_ready  = w_pixel_ready;
    assign o_sr_enable    = w_accept;
    assign o_sr_pixel     = i_pixel;
    assign o_window_valid = r_window_valid;
    assign o_win_col      = r_win_col;
    assign o_win_row      = r_win_row;
    assign o_frame_done   = w_frame_done;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conv_sr_feeder.sv
// Self-checking bench for conv_sr_feeder: vector table, reset sequence and
// whole frames checked against a pixel-count reference model.
module tb_conv_sr_feeder;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int P    = 3;
    localparam int R    = 3;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - P + 1) * (H - R + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pixel = 8'd0;
    logic       pvalid = 1'b0;
    logic       wready = 1'b0;
    logic       pready;
    logic       sren;
    logic [7:0] srpix;
    logic       wv;
    logic [2:0] wcol;
    logic [2:0] wrow;
    logic       fdone;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame active flag, pixels accepted, pending window.
    bit m_active = 1'b0;
    int m_n      = 0;
    bit m_pend   = 1'b0;
    int m_wc     = 0;
    int m_wr     = 0;

    always #5 clk = ~clk;

    conv_sr_feeder #(
        .P_SR_DEPTH  (P),
        .NUM_SR_ROWS (R),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_pixel        (pixel),
        .i_pixel_valid  (pvalid),
        .o_pixel_ready  (pready),
        .o_sr_enable    (sren),
        .o_sr_pixel     (srpix),
        .o_window_valid (wv),
        .i_window_ready (wready),
        .o_win_col      (wcol),
        .o_win_row      (wrow),
        .o_frame_done   (fdone),
        .o_busy         (busy)
    );

    typedef struct {
        logic       start;
        logic       valid;
        logic       wready;
        logic [7:0] pix;
        logic       e_ready;
        logic       e_en;
        logic       e_busy;
        logic       e_wv;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare the sampled outputs with the model, then advance the model by one edge.
    task automatic step_check(output bit acc);
        bit e_ready;
        bit e_en;
        bit e_fd;
        bit qual;
        e_ready = m_active && (m_n < NPIX) && !(m_pend && !wready);
        e_en    = e_ready && pvalid;
        e_fd    = m_active && (m_n == NPIX) && m_pend && wready;
        chk("pixel_ready", pready, e_ready);
        chk("sr_enable", sren, e_en);
        chk("sr_pixel", srpix, pixel);
        chk("window_valid", wv, m_pend);
        if (m_pend) begin
            chk("win_col", wcol, m_wc);
            chk("win_row", wrow, m_wr);
        end
        chk("frame_done", fdone, e_fd);
        chk("busy", busy, m_active);
        if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_n      = 0;
            end
            if (wready) m_pend = 1'b0;
        end else begin
            qual = e_en && (m_n % W >= P - 1) && (m_n / W >= R - 1);
            if (qual) begin
                m_pend = 1'b1;
                m_wc   = m_n % W;
                m_wr   = m_n / W;
            end else if (wready) begin
                m_pend = 1'b0;
            end
            if (e_en) m_n++;
            if (e_fd) m_active = 1'b0;
        end
        acc = e_en;
    endtask

    // mode 0: streaming, 1: backpressure at first window, 2: bubbles,
    // 3: start pulsed mid-frame, 4: random valid/ready/start
    task automatic run_frame(input int mode);
        int cyc = 0;
        int n_en = 0;
        int n_win = 0;
        int n_fd = 0;
        int stall = 0;
        int first_r = -1;
        int first_c = -1;
        int first_cyc = -1;
        int acc18_cyc = -1;
        int n_before;
        bit acc;
        bit done = 1'b0;
        bit stall_done = 1'b0;
        bit stalling;
        bit prev_low_col = 1'b0;
        bit start_sent = 1'b0;

        @(negedge clk);
        start  = 1'b1;
        pvalid = 1'b1;
        wready = 1'b1;
        pixel  = 8'hEE;
        #1;
        step_check(acc);

        while (!done && cyc < 2000) begin
            @(negedge clk);
            start    = 1'b0;
            pvalid   = 1'b1;
            wready   = 1'b1;
            stalling = 1'b0;
            pixel    = 8'(m_n);
            case (mode)
                1: begin
                    if (!stall_done && m_pend) begin
                        wready   = 1'b0;
                        stalling = 1'b1;
                    end
                end
                2: pvalid = (cyc % 2 == 0);
                3: begin
                    if (m_n == 30 && !start_sent) begin
                        start      = 1'b1;
                        start_sent = 1'b1;
                    end
                end
                4: begin
                    pvalid = ($urandom_range(0, 3) != 0);
                    wready = ($urandom_range(0, 2) != 0);
                    start  = ($urandom_range(0, 9) == 0);
                    pixel  = 8'($urandom);
                end
                default: ;
            endcase
            #1;
            if (wv && first_r < 0) begin
                first_r   = wrow;
                first_c   = wcol;
                first_cyc = cyc;
            end
            if (wv && wready) begin
                n_win++;
                $display("mode %0d window row=%0d col=%0d", mode, wrow, wcol);
            end
            if (sren) n_en++;
            if (fdone) begin
                n_fd++;
                done = 1'b1;
            end
            if ((mode == 0 || mode == 3) && prev_low_col) chk("rowwrap_no_window", wv, 1'b0);
            if (mode == 2) chk("bubble_sr_enable", sren, pvalid);
            if (stalling) begin
                chk("bp_pixel_ready", pready, 1'b0);
                chk("bp_sr_enable", sren, 1'b0);
                chk("bp_win_col", wcol, 2);
                chk("bp_win_row", wrow, 2);
            end
            n_before = m_n;
            step_check(acc);
            if (acc && n_before == 18) acc18_cyc = cyc;
            prev_low_col = acc && (n_before % W < P - 1);
            if (stalling) begin
                stall++;
                if (stall == 5) stall_done = 1'b1;
            end
            cyc++;
        end

        chk("frame_completed", done, 1'b1);
        chk("enable_count", n_en, NPIX);
        chk("window_count", n_win, NWIN);
        chk("frame_done_count", n_fd, 1);
        chk("first_win_row", first_r, R - 1);
        chk("first_win_col", first_c, P - 1);
        if (mode == 0) chk("first_window_latency", first_cyc - acc18_cyc, 1);
        if (mode == 1) chk("bp_stall_cycles", stall, 5);

        @(negedge clk);
        start  = 1'b0;
        pvalid = 1'b1;
        wready = 1'b1;
        #1;
        step_check(acc);
        $display("mode %0d frame complete in %0d cycles", mode, cyc);
    endtask

    initial begin
        bit acc;

        vecs[0] = '{start:1'b0, valid:1'b1, wready:1'b1, pix:8'h11, e_ready:1'b0, e_en:1'b0, e_busy:1'b0, e_wv:1'b0};
        vecs[1] = '{start:1'b1, valid:1'b1, wready:1'b1, pix:8'h22, e_ready:1'b0, e_en:1'b0, e_busy:1'b0, e_wv:1'b0};
        vecs[2] = '{start:1'b0, valid:1'b1, wready:1'b1, pix:8'h33, e_ready:1'b1, e_en:1'b1, e_busy:1'b1, e_wv:1'b0};
        vecs[3] = '{start:1'b1, valid:1'b0, wready:1'b1, pix:8'h44, e_ready:1'b1, e_en:1'b0, e_busy:1'b1, e_wv:1'b0};
        vecs[4] = '{start:1'b0, valid:1'b1, wready:1'b0, pix:8'h55, e_ready:1'b1, e_en:1'b1, e_busy:1'b1, e_wv:1'b0};
        vecs[5] = '{start:1'b0, valid:1'b0, wready:1'b0, pix:8'h66, e_ready:1'b1, e_en:1'b0, e_busy:1'b1, e_wv:1'b0};
        vecs[6] = '{start:1'b0, valid:1'b1, wready:1'b1, pix:8'h77, e_ready:1'b1, e_en:1'b1, e_busy:1'b1, e_wv:1'b0};

        // Power-on reset
        @(negedge clk);
        pvalid = 1'b1;
        pixel  = 8'hA5;
        #1;
        chk("reset_pixel_ready", pready, 1'b0);
        chk("reset_sr_enable", sren, 1'b0);
        chk("reset_window_valid", wv, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_sr_pixel", srpix, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start  = vecs[i].start;
            pvalid = vecs[i].valid;
            wready = vecs[i].wready;
            pixel  = vecs[i].pix;
            #1;
            chk("vec_pixel_ready", pready, vecs[i].e_ready);
            chk("vec_sr_enable", sren, vecs[i].e_en);
            chk("vec_busy", busy, vecs[i].e_busy);
            chk("vec_window_valid", wv, vecs[i].e_wv);
            chk("vec_sr_pixel", srpix, vecs[i].pix);
            step_check(acc);
            $display("vector %0d start=%0b valid=%0b ready=%0b -> en=%0b busy=%0b", i,
                     vecs[i].start, vecs[i].valid, vecs[i].wready, sren, busy);
        end

        // Run into a stalled first window, then reset mid-frame.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            start  = 1'b0;
            pvalid = 1'b1;
            wready = 1'b0;
            pixel  = 8'(i);
            #1;
            step_check(acc);
        end
        chk("pre_reset_window_valid", wv, 1'b1);

        @(negedge clk);
        rst_n  = 1'b0;
        pvalid = 1'b1;
        wready = 1'b0;
        pixel  = 8'h5A;
        #1;
        chk("midreset_pixel_ready", pready, 1'b0);
        chk("midreset_sr_enable", sren, 1'b0);
        chk("midreset_window_valid", wv, 1'b0);
        chk("midreset_win_col", wcol, 0);
        chk("midreset_win_row", wrow, 0);
        chk("midreset_frame_done", fdone, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_sr_pixel", srpix, 8'h5A);
        $display("mid-frame reset applied");
        m_active = 1'b0;
        m_n      = 0;
        m_pend   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start  = 1'b0;
            pvalid = 1'b1;
            wready = 1'b1;
            pixel  = 8'(8'hC0 + i);
            #1;
            step_check(acc);
        end

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(4);
        run_frame(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
